// File: rtl/neuron_pkg.sv
// neuron_pkg: shared width defaults, Q8.8 fraction width and FSM state type for the neuron sequencer
package neuron_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int ACC_W_DEF  = 40;
    localparam int FRAC_W     = 8;
    typedef enum logic [1:0] {IDLE, WAIT, MAC, DONE} state_t;
endpackage

// File: rtl/neuron_if.sv
// neuron_if: control, weight-ROM, input-stream and result signals of one neuron sequencer
interface neuron_if import neuron_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              start;
    logic              busy;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic [DATA_W-1:0] x_data;
    logic              x_valid;
    logic              x_ready;
    logic [DATA_W-1:0] y_data;
    logic              y_fire;
    logic              y_valid;
    logic              y_ready;
    modport master (
        output start, rom_dout, x_data, x_valid, y_ready,
        input  busy, rom_addr, x_ready, y_data, y_fire, y_valid
    );
    modport slave (
        input  start, rom_dout, x_data, x_valid, y_ready,
        output busy, rom_addr, x_ready, y_data, y_fire, y_valid
    );
endinterface

// File: rtl/neuron_mac.sv
// neuron_mac: signed Q8.8 multiply-accumulate with Q8.8 readout; define NEURON_SAT_EN for a saturating readout, otherwise it wraps
module neuron_mac import neuron_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic        [DATA_W-1:0] y,
    output logic                     fire
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    assign prod = a * b;
    // accumulator: cleared when an evaluation starts, one sign-extended product added per accepted input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else if (clr) acc <= '0;
        else if (en) acc <= acc + ACC_W'(prod);
    end
`ifdef NEURON_SAT_EN
    localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] sh;
    assign sh = acc >>> FRAC_W;
    assign y  = sh > HI ? {1'b0, {(DATA_W-1){1'b1}}} :
                sh < LO ? {1'b1, {(DATA_W-1){1'b0}}} : sh[DATA_W-1:0];
`else
    assign y  = DATA_W'(acc >>> FRAC_W);
`endif
    assign fire = !y[DATA_W-1] && (|y);
endmodule

// File: rtl/neuron_seq.sv
// neuron_seq: per input, fetch weight k from the ROM, wait its read cycle, accept input k and accumulate; then hold the result until acknowledged
module neuron_seq import neuron_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int N_INPUTS = 10,
    parameter int ACC_W    = ACC_W_DEF
) (
    input logic     clk,
    input logic     rst,
    neuron_if.slave bus
);
    state_t            state, state_d;
    logic [ADDR_W-1:0] idx, idx_d, addr, addr_d;
    logic              clr, en, last;
    assign last = idx == ADDR_W'(N_INPUTS);
    // state, input index and registered ROM address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            addr  <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            addr  <= addr_d;
        end
    end
    // next state, index/address advance and accumulator clear/enable
    always_comb begin
        state_d = state;
        idx_d   = idx;
        addr_d  = addr;
        clr     = 1'b0;
        en      = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                clr     = 1'b1;
                idx_d   = ADDR_W'(1);
                addr_d  = ADDR_W'(1);
                state_d = WAIT;
            end
            WAIT: state_d = MAC;
            MAC: if (bus.x_valid) begin
                en      = 1'b1;
                idx_d   = last ? idx : idx + ADDR_W'(1);
                addr_d  = last ? addr : idx + ADDR_W'(1);
                state_d = last ? DONE : WAIT;
            end
            default: if (bus.y_ready) state_d = IDLE;
        endcase
    end
    assign bus.busy     = state != IDLE;
    assign bus.x_ready  = state == MAC;
    assign bus.y_valid  = state == DONE;
    assign bus.rom_addr = addr;
    neuron_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (en),
        .a    (bus.x_data),
        .b    (bus.rom_dout),
        .y    (bus.y_data),
        .fire (bus.y_fire)
    );
endmodule
